// File: rtl/md_ring_pkg.sv
// Shared ring packet format: widths, field offsets and packing helpers used by the
// injector, the ring node and the receive-side force cache.
package md_ring_pkg;

    localparam int unsigned NUM_CELLS         = 64;
    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned PARTICLE_ID_WIDTH = 7;

    localparam int unsigned NODE_ID_WIDTH     = $clog2(NUM_CELLS);
    localparam int unsigned FORCE_CACHE_WIDTH = 3 * DATA_WIDTH;
    localparam int unsigned FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH;
    localparam int unsigned PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH;

    // Packet layout, LSB first: particle_id, fx, fy, fz, dest_id
    localparam int unsigned PID_LSB  = 0;
    localparam int unsigned FX_LSB   = PID_LSB + PARTICLE_ID_WIDTH;
    localparam int unsigned FY_LSB   = FX_LSB + DATA_WIDTH;
    localparam int unsigned FZ_LSB   = FY_LSB + DATA_WIDTH;
    localparam int unsigned DEST_LSB = FORCE_DATA_WIDTH;

    function automatic logic [PACKET_WIDTH-1:0] pack_force_pkt(
        input logic [NODE_ID_WIDTH-1:0]     dest,
        input logic [FORCE_CACHE_WIDTH-1:0] frc,
        input logic [PARTICLE_ID_WIDTH-1:0] pid
    );
        return {dest, frc, pid};
    endfunction

    // +0 and -0 both count as zero, so the sign bit is ignored
    function automatic logic is_zero_force(input logic [FORCE_CACHE_WIDTH-1:0] frc);
        logic zx, zy, zz;
        zx = (frc[DATA_WIDTH-2:0] == '0);
        zy = (frc[DATA_WIDTH+DATA_WIDTH-2:DATA_WIDTH] == '0);
        zz = (frc[2*DATA_WIDTH+DATA_WIDTH-2:2*DATA_WIDTH] == '0);
        return zx && zy && zz;
    endfunction

endpackage

// File: rtl/injector_fifo.sv
// Synchronous FIFO carrying a packet plus its end-of-batch flag; the head entry is
// presented combinationally and reads as zero while empty.
module injector_fifo #(
    parameter int unsigned WIDTH = 109,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_last,
    input  logic                       i_pop,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_last,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem      [DEPTH];
    logic             r_last_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on stored occupancy: a full FIFO cannot accept while popping
    assign o_ready = (r_count < CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && o_valid;

    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_last  = o_valid && r_last_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr]      <= i_data;
            r_last_mem[r_wptr] <= i_last;
        end
    end

endmodule

// File: rtl/force_pkt_injector.sv
// Ring injector: filters zero-force results, packs them into ring packets, buffers them
// and reports batch completion and delivery count to the cell controller.
module force_pkt_injector
    import md_ring_pkg::*;
#(
    parameter int unsigned NUM_CELLS         = 64,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PARTICLE_ID_WIDTH = 7,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter bit          DROP_ZERO         = 1'b1,
    localparam int unsigned NODE_ID_WIDTH     = $clog2(NUM_CELLS),
    localparam int unsigned FORCE_CACHE_WIDTH = 3 * DATA_WIDTH,
    localparam int unsigned FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH,
    localparam int unsigned PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH,
    localparam int unsigned COUNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pe_valid,
    output logic                         pe_ready,
    input  logic [NODE_ID_WIDTH-1:0]     pe_dest_cell,
    input  logic [PARTICLE_ID_WIDTH-1:0] pe_particle_id,
    input  logic [FORCE_CACHE_WIDTH-1:0] pe_force,
    input  logic                         pe_last,
    output logic [PACKET_WIDTH-1:0]      packet_out,
    output logic                         packet_valid,
    input  logic                         ring_ready,
    output logic [COUNT_WIDTH-1:0]       fifo_count,
    output logic                         drained,
    output logic                         batch_done,
    output logic [15:0]                  sent_count
);

    logic [PACKET_WIDTH-1:0] w_packet;
    logic                    w_zero;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head_last;
    logic                    r_batch_done;
    logic [15:0]             r_sent_count;

    // Shared helpers apply when this instance uses the ring-wide widths
    if (DATA_WIDTH == md_ring_pkg::DATA_WIDTH &&
        PARTICLE_ID_WIDTH == md_ring_pkg::PARTICLE_ID_WIDTH &&
        NODE_ID_WIDTH == md_ring_pkg::NODE_ID_WIDTH) begin : gen_pkg_fmt
        assign w_packet = pack_force_pkt(pe_dest_cell, pe_force, pe_particle_id);
        assign w_zero   = is_zero_force(pe_force);
    end else begin : gen_local_fmt
        assign w_packet = {pe_dest_cell, pe_force, pe_particle_id};
        assign w_zero   = (pe_force[DATA_WIDTH-2:0] == '0) &&
                          (pe_force[2*DATA_WIDTH-2:DATA_WIDTH] == '0) &&
                          (pe_force[3*DATA_WIDTH-2:2*DATA_WIDTH] == '0);
    end

    assign w_accept = pe_valid && pe_ready;
    // Zero results are swallowed unless they close a batch
    assign w_push   = w_accept && !(DROP_ZERO && w_zero && !pe_last);
    assign w_pop    = packet_valid && ring_ready;

    injector_fifo #(
        .WIDTH(PACKET_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (w_packet),
        .i_last  (pe_last),
        .i_pop   (w_pop),
        .o_ready (pe_ready),
        .o_valid (packet_valid),
        .o_data  (packet_out),
        .o_last  (w_head_last),
        .o_count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_batch_done <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_batch_done <= w_pop && w_head_last;
            if (w_pop) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
        end
    end

    assign drained    = (fifo_count == '0);
    assign batch_done = r_batch_done;
    assign sent_count = r_sent_count;

endmodule

// File: tb/tb_force_pkt_injector.sv
// Directed bench for force_pkt_injector with hand-computed expected packets.
module tb_force_pkt_injector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pe_valid = 1'b0;
    logic         pe_ready;
    logic [5:0]   pe_dest_cell = '0;
    logic [6:0]   pe_particle_id = '0;
    logic [95:0]  pe_force = '0;
    logic         pe_last = 1'b0;
    logic [108:0] packet_out;
    logic         packet_valid;
    logic         ring_ready = 1'b0;
    logic [3:0]   fifo_count;
    logic         drained;
    logic         batch_done;
    logic [15:0]  sent_count;

    int n_checks = 0;
    int n_errors = 0;

    force_pkt_injector dut (
        .clk            (clk),
        .rst            (rst),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .pe_dest_cell   (pe_dest_cell),
        .pe_particle_id (pe_particle_id),
        .pe_force       (pe_force),
        .pe_last        (pe_last),
        .packet_out     (packet_out),
        .packet_valid   (packet_valid),
        .ring_ready     (ring_ready),
        .fifo_count     (fifo_count),
        .drained        (drained),
        .batch_done     (batch_done),
        .sent_count     (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [108:0] mkpkt(input logic [5:0] d, input logic [31:0] fz,
                                           input logic [31:0] fy, input logic [31:0] fx,
                                           input logic [6:0] p);
        return {d, fz, fy, fx, p};
    endfunction

    function automatic logic [108:0] bp_pkt(input int i);
        return mkpkt(6'(i), 32'h4000_0000, 32'(i), 32'h1000 + 32'(i), 7'(10 + i));
    endfunction

    task automatic put(input logic v, input logic [5:0] d, input logic [6:0] p,
                       input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz,
                       input logic l);
        pe_valid       = v;
        pe_dest_cell   = d;
        pe_particle_id = p;
        pe_force       = {fz, fy, fx};
        pe_last        = l;
    endtask

    task automatic put_bp(input int i);
        put(1'b1, 6'(i), 7'(10 + i), 32'h1000 + 32'(i), 32'(i), 32'h4000_0000, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #3;
        check("rst_valid", 128'(packet_valid), 128'd0);
        check("rst_pkt", 128'(packet_out), 128'd0);
        check("rst_ready", 128'(pe_ready), 128'd1);
        check("rst_count", 128'(fifo_count), 128'd0);
        check("rst_drained", 128'(drained), 128'd1);
        check("rst_batch", 128'(batch_done), 128'd0);
        check("rst_sent", 128'(sent_count), 128'd0);
        #9 rst = 1'b1;

        // Single result, latency one cycle
        ring_ready = 1'b1;
        put(1'b1, 6'd5, 7'd3, 32'h3F80_0000, 32'h0, 32'h0, 1'b0);
        tick();
        check("single_valid", 128'(packet_valid), 128'd1);
        check("single_pkt", 128'(packet_out), 128'(mkpkt(6'd5, 32'h0, 32'h0, 32'h3F80_0000, 7'd3)));
        pe_valid = 1'b0;
        tick();
        check("single_sent", 128'(sent_count), 128'd1);
        check("single_drained", 128'(drained), 128'd1);

        // Backpressure: fill to eight
        ring_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put_bp(i);
            tick();
            check("bp_head", 128'(packet_out), 128'(bp_pkt(0)));
        end
        check("bp_count", 128'(fifo_count), 128'd8);
        check("bp_ready", 128'(pe_ready), 128'd0);
        // Full with ring_ready: pop happens, new result must not be taken
        ring_ready = 1'b1;
        put(1'b1, 6'd63, 7'd99, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b0);
        tick();
        check("full_no_accept", 128'(fifo_count), 128'd7);
        check("full_ready_back", 128'(pe_ready), 128'd1);
        check("bp_pkt1", 128'(packet_out), 128'(bp_pkt(1)));
        pe_valid = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                check("bp_order", 128'(packet_out), 128'(bp_pkt(i)));
                check("bp_valid", 128'(packet_valid), 128'd1);
            end
        end
        check("bp_drained", 128'(drained), 128'd1);
        check("bp_sent", 128'(sent_count), 128'd9);

        // Zero filter: nonzero, +0, -0, nonzero
        put(1'b1, 6'd1, 7'd1, 32'h3F00_0000, 32'h0, 32'h0, 1'b0);
        tick();
        check("zf_first", 128'(packet_out), 128'(mkpkt(6'd1, 32'h0, 32'h0, 32'h3F00_0000, 7'd1)));
        put(1'b1, 6'd2, 7'd2, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        check("zf_ready", 128'(pe_ready), 128'd1);
        put(1'b1, 6'd3, 7'd3, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        tick();
        check("zf_dropped", 128'(fifo_count), 128'd0);
        put(1'b1, 6'd4, 7'd4, 32'h0, 32'h0, 32'hBF80_0000, 1'b0);
        tick();
        check("zf_last", 128'(packet_out), 128'(mkpkt(6'd4, 32'hBF80_0000, 32'h0, 32'h0, 7'd4)));
        pe_valid = 1'b0;
        tick();
        tick();
        check("zf_sent", 128'(sent_count), 128'd11);

        // Zero-force with last is forwarded and closes the batch
        ring_ready = 1'b0;
        put(1'b1, 6'd7, 7'd9, 32'h0, 32'h0, 32'h8000_0000, 1'b1);
        tick();
        pe_valid = 1'b0;
        check("last_kept", 128'(packet_out), 128'(mkpkt(6'd7, 32'h8000_0000, 32'h0, 32'h0, 7'd9)));
        check("last_no_batch", 128'(batch_done), 128'd0);
        ring_ready = 1'b1;
        tick();
        check("batch_pulse", 128'(batch_done), 128'd1);
        check("last_sent", 128'(sent_count), 128'd12);
        tick();
        check("batch_single", 128'(batch_done), 128'd0);

        // Push and pop together at occupancy three
        ring_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_bp(20 + i);
            tick();
        end
        check("pp_count3", 128'(fifo_count), 128'd3);
        ring_ready = 1'b1;
        put_bp(23);
        tick();
        pe_valid = 1'b0;
        check("pp_count_hold", 128'(fifo_count), 128'd3);
        check("pp_head", 128'(packet_out), 128'(bp_pkt(21)));
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("pp_drained", 128'(drained), 128'd1);
        check("pp_sent", 128'(sent_count), 128'd16);

        // Asynchronous reset with four queued
        ring_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_bp(30 + i);
            tick();
        end
        pe_valid = 1'b0;
        check("ar_count4", 128'(fifo_count), 128'd4);
        #2 rst = 1'b0;
        #1;
        check("ar_valid", 128'(packet_valid), 128'd0);
        check("ar_count", 128'(fifo_count), 128'd0);
        check("ar_sent", 128'(sent_count), 128'd0);
        check("ar_ready", 128'(pe_ready), 128'd1);
        #1 rst = 1'b1;
        ring_ready = 1'b1;
        put(1'b1, 6'd33, 7'd44, 32'hC000_0000, 32'h0, 32'h0, 1'b0);
        tick();
        pe_valid = 1'b0;
        check("ar_restart", 128'(packet_out), 128'(mkpkt(6'd33, 32'h0, 32'h0, 32'hC000_0000, 7'd44)));
        check("ar_restart_cnt", 128'(fifo_count), 128'd1);
        tick();
        check("ar_restart_sent", 128'(sent_count), 128'd1);
        check("ar_restart_drn", 128'(drained), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/force_pkt_injector.md
# force_pkt_injector

Upstream stage of the ring interconnect, one instance per cell. It accepts force results from the cell's force-evaluation PE and buffers them in a small FIFO. It packs each result as `{dest_id, force, particle_id}` and presents it to the ring node's PE port under a valid/ready handshake. It optionally discards zero-force results and reports batch completion and drain status to the cell controller.

## Interface
Parameters:
- `NUM_CELLS`, 64: cells on the ring; `NODE_ID_WIDTH = $clog2(NUM_CELLS)`.
- `DATA_WIDTH`, 32: width of one force component (FP32).
- `PARTICLE_ID_WIDTH`, 7: particle index width within a cell.
- `FIFO_DEPTH`, 8: entries; power of two, ≥2.
- `DROP_ZERO`, 1: 1 = discard zero-force results, 0 = forward every result.
- Derived: `FORCE_CACHE_WIDTH = 3*DATA_WIDTH`, `FORCE_DATA_WIDTH = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH`, `PACKET_WIDTH = FORCE_DATA_WIDTH + NODE_ID_WIDTH`.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `pe_valid`, in, 1: PE result valid.
- `pe_ready`, out, 1: injector can accept.
- `pe_dest_cell`, in, NODE_ID_WIDTH: destination cell.
- `pe_particle_id`, in, PARTICLE_ID_WIDTH: particle index within the destination cell.
- `pe_force`, in, FORCE_CACHE_WIDTH: `{fz, fy, fx}`, fx in the LSBs.
- `pe_last`, in, 1: marks the final result of a batch.
- `packet_out`, out, PACKET_WIDTH: `{dest_id, fz, fy, fx, particle_id}`, to ring `packet_in[i]`.
- `packet_valid`, out, 1: to ring `packet_valid[i]`.
- `ring_ready`, in, 1: from ring `ready[i]`.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- `drained`, out, 1: FIFO empty.
- `batch_done`, out, 1: single-cycle pulse.
- `sent_count`, out, 16: packets delivered to the ring; wraps at 2^16.

## Operation
- Input transfer: `pe_valid && pe_ready` at a rising edge.
- Output transfer: `packet_valid && ring_ready` at a rising edge.
- `pe_ready = (fifo_count < FIFO_DEPTH)`, purely registered-state based. There is no full-bypass, so a full FIFO does not accept in the same cycle it pops.
- Zero test: a component is zero when its bits `[DATA_WIDTH-2:0]` are all 0 (±0). A result is zero-force when all three components are zero.
- Drop rule (`DROP_ZERO=1`): an accepted zero-force result with `pe_last=0` is consumed and not written to the FIFO. `pe_ready` is unaffected. A zero-force result with `pe_last=1` is always written.
- Each FIFO entry stores the packed packet plus the last flag.
- The head entry drives `packet_out`. `packet_valid = !empty`.
- `packet_out` and `packet_valid` change only after an output transfer or a push into an empty FIFO.
- Push and pop in the same cycle leave `fifo_count` unchanged. The read and write pointers wrap modulo FIFO_DEPTH.
- `batch_done`: asserted for one cycle, the cycle after the output transfer of an entry whose last flag is set.
- `sent_count`: increments by 1 on every output transfer.
- `drained`: equals `fifo_count == 0`.
- Reset: `rst` low clears the pointers, count, `sent_count` and `batch_done` immediately. Contents in flight are lost; a mid-operation reset discards all queued packets.

## Timing
- Reset values: `packet_valid`=0, `packet_out`=0, `pe_ready`=1, `fifo_count`=0, `drained`=1, `batch_done`=0, `sent_count`=0.
- Latency: a result accepted at edge N into an empty FIFO gives `packet_valid`=1 with that packet from after edge N (cycle N+1).
- Throughput: one packet per cycle while `ring_ready` is held high.
- `packet_out` is held stable while `packet_valid && !ring_ready`.
- `ring_ready` may toggle arbitrarily. `packet_valid` never deasserts without a transfer.
- `fifo_count` and `drained` reflect state after the previous edge.

## Structure
- Shared package `md_ring_pkg` holds:
  - the width constants (`NODE_ID_WIDTH`, `FORCE_CACHE_WIDTH`, `FORCE_DATA_WIDTH`, `PACKET_WIDTH`);
  - the packet field offsets;
  - function `pack_force_pkt(dest, force, pid)`;
  - function `is_zero_force(force)`.
- The same package is used by the ring node and the receive-side force cache.
- One sub-module, `injector_fifo`: a parameterised synchronous FIFO (data + last flag, count output).
- The top level holds the drop filter, packing, `batch_done` and `sent_count` logic.

## Test plan
- Single result (dest=5, pid=3, fx=0x3F800000, fy=0, fz=0) with `ring_ready`=1: packet_out = {5, 0, 0, 0x3F800000, 3} valid the cycle after acceptance; `sent_count`=1.
- Backpressure: push 8 results with `ring_ready`=0. Then `fifo_count`=8, `pe_ready`=0, and `packet_out` stays on entry 0. Release `ring_ready`: 8 packets in order in 8 consecutive cycles, `drained`=1 after the last.
- Zero filter, `DROP_ZERO=1`: push results with forces nonzero, zero, -0 (0x80000000 in all components), nonzero. Exactly 2 packets emitted.
- Zero-force result with `pe_last`=1: it is forwarded, and `batch_done` pulses once, the cycle after it leaves.
- Simultaneous push and pop at `fifo_count`=3: count stays 3. With the FIFO full and `ring_ready`=1, `pe_valid` is not accepted that cycle.
- Assert `rst` low with 4 entries queued: `packet_valid`=0, `fifo_count`=0 and `sent_count`=0 asynchronously. After release, operation restarts cleanly from an empty FIFO.
